alu_arbiter: RTL and testbench



---
 rtl/alu_arbiter_pkg.sv | 24 ++
 rtl/alu_arbiter_rr_arb2.sv | 25 ++
 rtl/alu_arbiter.sv | 133 +++++++++++++
 tb/tb_alu_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU sequencer/arbiter: widths, ALU opcodes and FSM states.
package alu_arbiter_pkg;

   localparam int ALU_DATA_WIDTH = 32;
   localparam int ALU_OPRN_WIDTH = 6;
   localparam int ALU_OPRN_MAX   = 9;

   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_ADD = 6'h01;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_SUB = 6'h02;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_MUL = 6'h03;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_SHR = 6'h04;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_SHL = 6'h05;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_AND = 6'h06;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_OR  = 6'h07;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_NOR = 6'h08;
   localparam logic [ALU_OPRN_WIDTH-1:0] OPRN_SLT = 6'h09;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin picker; on a tie the requester that was not granted last wins.
module alu_arbiter_rr_arb2 (
   input  logic       clk,
   input  logic       srst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // Starts at 1 so that requester 0 wins the first tie after reset.
   logic last_gnt_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_pick
      assign gnt[gi] = req[gi] && (!req[1-gi] || (last_gnt_reg != 1'(gi)));
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         last_gnt_reg <= 1'b1;
      end else if (advance) begin
         last_gnt_reg <= gnt[1];
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: req/gnt in, registered result out
// under a valid/ack handshake. One operation per three cycles at best.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = ALU_DATA_WIDTH,
   parameter int OPRN_WIDTH = ALU_OPRN_WIDTH,
   parameter int OPRN_MAX   = ALU_OPRN_MAX
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [1:0]            REQ,
   input  logic [DATA_WIDTH-1:0] OP1_0,
   input  logic [DATA_WIDTH-1:0] OP2_0,
   input  logic [OPRN_WIDTH-1:0] OPRN_0,
   input  logic [DATA_WIDTH-1:0] OP1_1,
   input  logic [DATA_WIDTH-1:0] OP2_1,
   input  logic [OPRN_WIDTH-1:0] OPRN_1,
   output logic [1:0]            GNT,
   output logic [1:0]            RSP_VALID,
   input  logic [1:0]            RSP_ACK,
   output logic [DATA_WIDTH-1:0] RSP_DATA,
   output logic                  RSP_ZERO,
   output logic                  RSP_ERR,
   output logic [DATA_WIDTH-1:0] ALU_OP1,
   output logic [DATA_WIDTH-1:0] ALU_OP2,
   output logic [OPRN_WIDTH-1:0] ALU_OPRN,
   input  logic [DATA_WIDTH-1:0] ALU_OUT,
   input  logic                  ALU_ZERO
);

   state_t                state_reg, state_next;
   logic                  winner_reg;
   logic [DATA_WIDTH-1:0] op1_reg, op2_reg;
   logic [OPRN_WIDTH-1:0] oprn_reg;
   logic                  illegal_reg;
   logic [DATA_WIDTH-1:0] rsp_data_reg;
   logic                  rsp_zero_reg;
   logic                  rsp_err_reg;

   logic [1:0]            arb_gnt;
   logic [1:0]            gnt_next;
   logic                  grant_fire;
   logic                  resp_done;
   logic [DATA_WIDTH-1:0] sel_op1, sel_op2;
   logic [OPRN_WIDTH-1:0] sel_oprn;
   logic                  sel_legal;

   alu_arbiter_rr_arb2 u_rr_arb2 (
      .clk     (CLK),
      .srst    (RST),
      .req     (REQ),
      .advance (grant_fire),
      .gnt     (arb_gnt)
   );

   assign grant_fire = (state_reg == ST_IDLE) && (|REQ);
   assign resp_done  = (state_reg == ST_RESP) && RSP_ACK[winner_reg];

   assign sel_op1   = arb_gnt[1] ? OP1_1  : OP1_0;
   assign sel_op2   = arb_gnt[1] ? OP2_1  : OP2_0;
   assign sel_oprn  = arb_gnt[1] ? OPRN_1 : OPRN_0;
   assign sel_legal = (sel_oprn != '0) && (int'(sel_oprn) <= OPRN_MAX);

   always_comb begin
      state_next = state_reg;
      gnt_next   = 2'b00;
      case (state_reg)
         ST_IDLE: begin
            if (|REQ) begin
               gnt_next   = arb_gnt;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: state_next = ST_RESP;
         ST_RESP: begin
            if (RSP_ACK[winner_reg]) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         winner_reg   <= 1'b0;
         op1_reg      <= '0;
         op2_reg      <= '0;
         oprn_reg     <= '0;
         illegal_reg  <= 1'b0;
         rsp_data_reg <= '0;
         rsp_zero_reg <= 1'b0;
         rsp_err_reg  <= 1'b0;
      end else begin
         if (grant_fire) begin
            winner_reg  <= arb_gnt[1];
            op1_reg     <= sel_op1;
            op2_reg     <= sel_op2;
            oprn_reg    <= sel_oprn;
            illegal_reg <= !sel_legal;
         end
         if (state_reg == ST_EXEC) begin
            // An illegal opcode never reaches the ALU, so its output is not trusted here.
            rsp_data_reg <= illegal_reg ? '0   : ALU_OUT;
            rsp_zero_reg <= illegal_reg ? 1'b0 : ALU_ZERO;
            rsp_err_reg  <= illegal_reg;
         end
         if (resp_done) begin
            rsp_err_reg <= 1'b0;
         end
      end
   end

   // Grant is combinational from REQ so the requester sees it in the cycle it is sampled.
   assign GNT       = RST ? 2'b00 : gnt_next;
   assign RSP_VALID = (state_reg == ST_RESP) ? (winner_reg ? 2'b10 : 2'b01) : 2'b00;
   assign RSP_DATA  = rsp_data_reg;
   assign RSP_ZERO  = rsp_zero_reg;
   assign RSP_ERR   = rsp_err_reg;
   assign ALU_OP1   = op1_reg;
   assign ALU_OP2   = op2_reg;
   assign ALU_OPRN  = ((state_reg == ST_EXEC) && !illegal_reg) ? oprn_reg : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU closing the loop.
module tb_alu_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  REQ;
   logic [31:0] OP1_0, OP2_0, OP1_1, OP2_1;
   logic [5:0]  OPRN_0, OPRN_1;
   logic [1:0]  GNT, RSP_VALID, RSP_ACK;
   logic [31:0] RSP_DATA;
   logic        RSP_ZERO, RSP_ERR;
   logic [31:0] ALU_OP1, ALU_OP2, ALU_OUT;
   logic [5:0]  ALU_OPRN;
   logic        ALU_ZERO;

   int n_cmp = 0;
   int n_err = 0;

   alu_arbiter dut (
      .CLK(CLK), .RST(RST), .REQ(REQ),
      .OP1_0(OP1_0), .OP2_0(OP2_0), .OPRN_0(OPRN_0),
      .OP1_1(OP1_1), .OP2_1(OP2_1), .OPRN_1(OPRN_1),
      .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_ACK(RSP_ACK),
      .RSP_DATA(RSP_DATA), .RSP_ZERO(RSP_ZERO), .RSP_ERR(RSP_ERR),
      .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
      .ALU_OUT(ALU_OUT), .ALU_ZERO(ALU_ZERO)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [5:0] op);
      case (op)
         6'h01:   return a + b;
         6'h02:   return a - b;
         6'h03:   return a * b;
         6'h04:   return a >> b[4:0];
         6'h05:   return a << b[4:0];
         6'h06:   return a & b;
         6'h07:   return a | b;
         6'h08:   return ~(a | b);
         6'h09:   return {31'b0, $signed(a) < $signed(b)};
         default: return 32'h0;
      endcase
   endfunction

   assign ALU_OUT  = alu_f(ALU_OP1, ALU_OP2, ALU_OPRN);
   assign ALU_ZERO = (ALU_OUT == 32'h0);

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   initial begin
      RST = 1'b1; REQ = 2'b00; RSP_ACK = 2'b00;
      OP1_0 = '0; OP2_0 = '0; OPRN_0 = '0;
      OP1_1 = '0; OP2_1 = '0; OPRN_1 = '0;
      tick(); tick();
      check("rst_gnt",   32'(GNT),       32'h0);
      check("rst_valid", 32'(RSP_VALID), 32'h0);
      check("rst_data",  RSP_DATA,       32'h0);
      check("rst_zero",  32'(RSP_ZERO),  32'h0);
      check("rst_err",   32'(RSP_ERR),   32'h0);
      check("rst_oprn",  32'(ALU_OPRN),  32'h0);
      RST = 1'b0;

      // 1: single requester, 15+3
      REQ = 2'b01; OP1_0 = 32'd15; OP2_0 = 32'd3; OPRN_0 = 6'h01;
      #1 check("t1_gnt", 32'(GNT), 32'h1);
      tick(); REQ = 2'b00; #1;
      check("t1_exec_gnt",   32'(GNT),       32'h0);
      check("t1_exec_valid", 32'(RSP_VALID), 32'h0);
      check("t1_exec_oprn",  32'(ALU_OPRN),  32'h1);
      check("t1_exec_op1",   ALU_OP1,        32'd15);
      tick();
      check("t1_valid", 32'(RSP_VALID), 32'h1);
      check("t1_data",  RSP_DATA,       32'd18);
      check("t1_zero",  32'(RSP_ZERO),  32'h0);
      check("t1_idle_oprn", 32'(ALU_OPRN), 32'h0);
      RSP_ACK = 2'b01; tick(); RSP_ACK = 2'b00;
      check("t1_valid_clr", 32'(RSP_VALID), 32'h0);

      // 2: tie after reset goes 0, then 1, then back to 0
      RST = 1'b1; tick(); RST = 1'b0;
      REQ = 2'b11;
      OP1_0 = 32'd8; OP2_0 = 32'd8; OPRN_0 = 6'h02;
      OP1_1 = 32'd3; OP2_1 = 32'd5; OPRN_1 = 6'h03;
      #1 check("t2_gnt0", 32'(GNT), 32'h1);
      tick(); REQ = 2'b10;
      tick();
      check("t2_valid0", 32'(RSP_VALID), 32'h1);
      check("t2_data0",  RSP_DATA,       32'd0);
      check("t2_zero0",  32'(RSP_ZERO),  32'h1);
      RSP_ACK = 2'b01; tick(); RSP_ACK = 2'b00;
      check("t2_gnt1", 32'(GNT), 32'h2);
      tick(); REQ = 2'b00;
      tick();
      check("t2_valid1", 32'(RSP_VALID), 32'h2);
      check("t2_data1",  RSP_DATA,       32'd15);
      check("t2_zero1",  32'(RSP_ZERO),  32'h0);
      RSP_ACK = 2'b10; tick(); RSP_ACK = 2'b00;
      REQ = 2'b11;
      OP1_0 = 32'd6; OP2_0 = 32'd3; OPRN_0 = 6'h06;
      #1 check("t2_gnt_tie", 32'(GNT), 32'h1);
      tick(); REQ = 2'b00;
      tick();
      check("t2_data_and", RSP_DATA, 32'd2);
      RSP_ACK = 2'b01; tick(); RSP_ACK = 2'b00;

      // 3: ack withheld 5 cycles, req1 pending meanwhile
      REQ = 2'b01; OP1_0 = 32'd24; OP2_0 = 32'd2; OPRN_0 = 6'h04;
      #1 check("t3_gnt0", 32'(GNT), 32'h1);
      tick();
      REQ = 2'b10; OP1_1 = 32'd7; OP2_1 = 32'd2; OPRN_1 = 6'h07;
      tick();
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_hold_valid%0d", i), 32'(RSP_VALID), 32'h1);
         check($sformatf("t3_hold_data%0d", i),  RSP_DATA,       32'd6);
         check($sformatf("t3_hold_gnt%0d", i),   32'(GNT),       32'h0);
         tick();
      end
      RSP_ACK = 2'b01; tick(); RSP_ACK = 2'b00;
      check("t3_gnt1", 32'(GNT), 32'h2);
      tick(); REQ = 2'b00;
      tick();
      check("t3_valid1", 32'(RSP_VALID), 32'h2);
      check("t3_data1",  RSP_DATA,       32'd7);
      RSP_ACK = 2'b10; tick(); RSP_ACK = 2'b00;

      // 4: illegal opcode from requester 1
      REQ = 2'b10; OP1_1 = 32'd9; OP2_1 = 32'd9; OPRN_1 = 6'h0C;
      #1 check("t4_gnt", 32'(GNT), 32'h2);
      tick(); REQ = 2'b00; #1;
      check("t4_exec_oprn", 32'(ALU_OPRN), 32'h0);
      tick();
      check("t4_valid", 32'(RSP_VALID), 32'h2);
      check("t4_err",   32'(RSP_ERR),   32'h1);
      check("t4_data",  RSP_DATA,       32'h0);
      check("t4_zero",  32'(RSP_ZERO),  32'h0);
      RSP_ACK = 2'b10; tick(); RSP_ACK = 2'b00;
      check("t4_err_clr", 32'(RSP_ERR), 32'h0);

      // 5: reset during EXEC aborts, then a fresh request is served
      REQ = 2'b01; OP1_0 = 32'd5; OP2_0 = 32'd3; OPRN_0 = 6'h05;
      #1 check("t5_gnt", 32'(GNT), 32'h1);
      tick(); REQ = 2'b00;
      check("t5_exec_op1", ALU_OP1, 32'd5);
      RST = 1'b1; tick();
      check("t5_rst_valid", 32'(RSP_VALID), 32'h0);
      check("t5_rst_op1",   ALU_OP1,        32'h0);
      check("t5_rst_op2",   ALU_OP2,        32'h0);
      check("t5_rst_oprn",  32'(ALU_OPRN),  32'h0);
      RST = 1'b0; tick();
      check("t5_no_resp", 32'(RSP_VALID), 32'h0);
      REQ = 2'b01;
      #1 check("t5_regnt", 32'(GNT), 32'h1);
      tick(); REQ = 2'b00;
      tick();
      check("t5_valid", 32'(RSP_VALID), 32'h1);
      check("t5_data",  RSP_DATA,       32'd40);

      // 6: ack on the wrong port is ignored
      RSP_ACK = 2'b10;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("t6_wrong_ack%0d", i), 32'(RSP_VALID), 32'h1);
      end
      RSP_ACK = 2'b01; tick(); RSP_ACK = 2'b00;
      check("t6_valid_clr", 32'(RSP_VALID), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
